fetch_queue: RTL and testbench

Instruction fetch queue sitting directly downstream of the next-PC stage and the instruction cache. It buffers aligned two-instruction fetch packets (one 8-byte group per push) and hands them one instruction per cycle to decode. It back-pressures the next-PC stage through its stall input and discards all buffered state on a branch-update flush.

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 123 ++++++++++++
 tb/tb_fetch_queue.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// -----------------------------------------------------------------------------
// fetch_queue_if
// Bundles the two handshakes of the instruction fetch queue.
//   Packet side : in_valid_i, in_ready_o, in_pc_i[31:0], in_inst_i[63:0]
//   Decode side : out_valid_o, out_ready_i, out_pc_o[31:0], out_inst_o[31:0]
// Both handshakes use valid/ready semantics: a transfer happens on a rising
// clock edge where valid and ready are both high. A producer never makes
// valid depend on ready. In this queue, ready and valid depend only on
// registered state and flush_i.
// Modports:
//   slave  : the queue itself
//   master : upstream fetch / downstream decode, or a testbench
// -----------------------------------------------------------------------------
interface fetch_queue_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] in_pc_i;
  logic [63:0] in_inst_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_inst_o;

  modport slave (
    input  in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    output in_ready_o, out_valid_o, out_pc_o, out_inst_o
  );

  modport master (
    output in_valid_i, in_pc_i, in_inst_i, out_ready_i,
    input  in_ready_o, out_valid_o, out_pc_o, out_inst_o
  );
endinterface

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Buffers aligned two-instruction fetch packets (one 8-byte group per push)
// and hands them to decode one instruction per cycle. Each entry stores
// the upper PC bits, both instruction words and a two-bit slot mask. If a
// packet starts on the upper word (pc[2] = 1), only that slot is marked
// valid.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset (same effect as a flush)
//   flush_i  : branch-update flush; drops all buffered packets
//   fq       : fetch_queue_if.slave (packet input + instruction output)
// Parameters:
//   DEPTH    : number of packet entries, power of two, >= 2
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush_i,
  fetch_queue_if.slave  fq
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Entry storage. The data arrays carry no reset because an entry is only
  // read while count says it holds a valid packet.
  logic [28:0] pc_hi_q [DEPTH];
  logic [63:0] inst_q  [DEPTH];
  logic [1:0]  mask_q  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic       push;
  logic       pop;
  logic       retire;
  logic [1:0] head_mask;
  logic       head_slot;
  logic [1:0] slot_bit;
  logic [1:0] head_mask_rem;
  logic [1:0] new_mask;
  logic       out_valid;
  logic       in_ready;

  // PC bits [1:0] are always zero for aligned fetch and are not stored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^fq.in_pc_i[1:0];

  always_comb begin
    out_valid     = (count_q != '0) & ~flush_i;
    // No full-queue bypass. A pop in the same cycle does not open the input.
    in_ready      = (count_q < CW'(DEPTH)) & ~flush_i;
    push          = fq.in_valid_i & in_ready;
    pop           = out_valid & fq.out_ready_i;

    head_mask     = mask_q[rd_ptr_q];
    // Lowest set bit picks the slot. A live entry always has a non-zero mask.
    head_slot     = ~head_mask[0];
    slot_bit      = head_slot ? 2'b10 : 2'b01;
    head_mask_rem = head_mask & ~slot_bit;
    retire        = pop & (head_mask_rem == 2'b00);

    new_mask      = fq.in_pc_i[2] ? 2'b10 : 2'b11;

    wr_ptr_d = push   ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = retire ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, retire})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: pointers, count and slot masks. A flush (or reset)
  // takes priority over any push or pop in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mask_q[i] <= 2'b00;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // A push and a pop never target the same entry. A push needs
      // count < DEPTH and a pop needs count > 0. So equal pointers cannot
      // occur here.
      if (pop) begin
        mask_q[rd_ptr_q] <= head_mask_rem;
      end
      if (push) begin
        mask_q[wr_ptr_q] <= new_mask;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_hi_q[wr_ptr_q] <= fq.in_pc_i[31:3];
      inst_q[wr_ptr_q]  <= fq.in_inst_i;
    end
  end

  always_comb begin
    fq.in_ready_o  = in_ready;
    fq.out_valid_o = out_valid;
    fq.out_pc_o    = '0;
    fq.out_inst_o  = '0;
    if (out_valid) begin
      fq.out_pc_o   = {pc_hi_q[rd_ptr_q], head_slot, 2'b00};
      fq.out_inst_o = head_slot ? inst_q[rd_ptr_q][63:32] : inst_q[rd_ptr_q][31:0];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
// Directed bench for fetch_queue (DEPTH = 4). Accepted packets are expanded
// into expected {pc, inst} items in exp_q. A monitor on the falling edge pops
// and compares every instruction that decode consumes. It also requires zero
// pc/inst outputs whenever out_valid_o is low. Inline checks cover latency,
// full/ready timing, flush and reset behaviour.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

  logic clk = 1'b0;
  logic rst;
  logic flush;

  always #5 clk = ~clk;

  fetch_queue_if bus();

  fetch_queue #(.DEPTH(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush_i (flush),
    .fq      (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (bus.out_valid_o && bus.out_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pc %h inst %h, expected nothing queued",
                 bus.out_pc_o, bus.out_inst_o);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_pc", bus.out_pc_o, mon_e[63:32]);
        check("out_inst", bus.out_inst_o, mon_e[31:0]);
      end
    end else if (bus.out_valid_o === 1'b0) begin
      check("idle_pc", bus.out_pc_o, 32'h0);
      check("idle_inst", bus.out_inst_o, 32'h0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one packet for one cycle; records expected instructions if taken.
  task automatic push_pkt(input logic [31:0] pc, input logic [63:0] inst);
    bus.in_valid_i = 1'b1;
    bus.in_pc_i    = pc;
    bus.in_inst_i  = inst;
    @(negedge clk);
    if (bus.in_ready_o) begin
      if (!pc[2]) exp_q.push_back({pc[31:3], 3'b000, inst[31:0]});
      exp_q.push_back({pc[31:3], 3'b100, inst[63:32]});
    end
    @(posedge clk);
    #1;
    bus.in_valid_i = 1'b0;
  endtask

  // Consumes everything; bounded wait on out_valid_o going low.
  task automatic drain(input string name);
    int n;
    n = 0;
    bus.out_ready_i = 1'b1;
    while (bus.out_valid_o && n < 20) begin
      tick();
      n++;
    end
    check({name, "_drained_valid"}, bus.out_valid_o, 1'b0);
    check({name, "_exp_left"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst             = 1'b1;
    flush           = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.in_pc_i     = '0;
    bus.in_inst_i   = '0;
    bus.out_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", bus.out_valid_o, 1'b0);
    check("rst_in_ready", bus.in_ready_o, 1'b1);
    check("rst_out_pc", bus.out_pc_o, 32'h0);
    check("rst_out_inst", bus.out_inst_o, 32'h0);

    // Aligned packet: two instructions, one cycle latency
    bus.out_ready_i = 1'b1;
    push_pkt(32'h1c000000, {32'h02800842, 32'h02800421});
    check("t1_valid", bus.out_valid_o, 1'b1);
    check("t1_pc0", bus.out_pc_o, 32'h1c000000);
    check("t1_inst0", bus.out_inst_o, 32'h02800421);
    tick();
    check("t1_pc1", bus.out_pc_o, 32'h1c000004);
    check("t1_inst1", bus.out_inst_o, 32'h02800842);
    tick();
    check("t1_empty", bus.out_valid_o, 1'b0);

    // Upper-slot packet: exactly one instruction
    push_pkt(32'h1c000014, {32'h4c000020, 32'h03400000});
    check("t2_pc", bus.out_pc_o, 32'h1c000014);
    check("t2_inst", bus.out_inst_o, 32'h4c000020);
    tick();
    check("t2_empty", bus.out_valid_o, 1'b0);

    // Fill to full, then ready returns only after the head retires
    bus.out_ready_i = 1'b0;
    push_pkt(32'h1c000020, {32'h00000202, 32'h00000201});
    push_pkt(32'h1c000028, {32'h00000282, 32'h00000281});
    push_pkt(32'h1c000030, {32'h00000302, 32'h00000301});
    check("t3_ready_3", bus.in_ready_o, 1'b1);
    push_pkt(32'h1c000038, {32'h00000382, 32'h00000381});
    check("t3_full_ready", bus.in_ready_o, 1'b0);
    bus.out_ready_i = 1'b1;
    check("t3_no_bypass", bus.in_ready_o, 1'b0);
    tick();
    check("t3_ready_slot0", bus.in_ready_o, 1'b0);
    tick();
    check("t3_ready_retired", bus.in_ready_o, 1'b1);
    drain("t3");

    // Push while the head's last slot retires: count stays 2
    bus.out_ready_i = 1'b0;
    push_pkt(32'h1c000044, {32'h0a0a0a0b, 32'h0a0a0a0a});
    push_pkt(32'h1c000048, {32'h0b0b0b02, 32'h0b0b0b01});
    bus.out_ready_i = 1'b1;
    push_pkt(32'h1c000050, {32'h0c0c0c02, 32'h0c0c0c01});
    bus.out_ready_i = 1'b0;
    check("t4_next_pc", bus.out_pc_o, 32'h1c000048);
    check("t4_next_inst", bus.out_inst_o, 32'h0b0b0b01);
    push_pkt(32'h1c000058, {32'h0d0d0d02, 32'h0d0d0d01});
    check("t4_ready_cnt3", bus.in_ready_o, 1'b1);
    push_pkt(32'h1c000060, {32'h0e0e0e02, 32'h0e0e0e01});
    check("t4_full_cnt4", bus.in_ready_o, 1'b0);
    drain("t4");

    // Flush with count 3, concurrent push and pop offered
    bus.out_ready_i = 1'b0;
    push_pkt(32'h1c000068, {32'h11110002, 32'h11110001});
    push_pkt(32'h1c000070, {32'h22220002, 32'h22220001});
    push_pkt(32'h1c000078, {32'h33330002, 32'h33330001});
    flush           = 1'b1;
    bus.in_valid_i  = 1'b1;
    bus.in_pc_i     = 32'h1c000080;
    bus.in_inst_i   = {32'h44440002, 32'h44440001};
    bus.out_ready_i = 1'b1;
    #1;
    check("t5_flush_valid", bus.out_valid_o, 1'b0);
    check("t5_flush_ready", bus.in_ready_o, 1'b0);
    exp_q.delete();
    tick();
    flush          = 1'b0;
    bus.in_valid_i = 1'b0;
    #1;
    check("t5_empty_valid", bus.out_valid_o, 1'b0);
    check("t5_empty_ready", bus.in_ready_o, 1'b1);
    push_pkt(32'h1c000100, {32'h02c00400, 32'h02c00200});
    check("t5_post_pc", bus.out_pc_o, 32'h1c000100);
    check("t5_post_inst", bus.out_inst_o, 32'h02c00200);
    drain("t5");

    // Reset mid-operation with 3 entries buffered
    bus.out_ready_i = 1'b0;
    push_pkt(32'h1c000108, {32'h55550002, 32'h55550001});
    push_pkt(32'h1c000114, {32'h66660002, 32'h66660001});
    push_pkt(32'h1c000118, {32'h77770002, 32'h77770001});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("t6_valid", bus.out_valid_o, 1'b0);
    check("t6_ready", bus.in_ready_o, 1'b1);
    check("t6_pc", bus.out_pc_o, 32'h0);
    check("t6_inst", bus.out_inst_o, 32'h0);
    bus.out_ready_i = 1'b1;
    push_pkt(32'h1c000200, {32'h88880002, 32'h88880001});
    check("t6_post_pc", bus.out_pc_o, 32'h1c000200);
    check("t6_post_inst", bus.out_inst_o, 32'h88880001);
    drain("t6");

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
